// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: turns EX_MEM loads/stores into a req/ack
// data-memory transaction, formats store lanes, extracts/extends load data
// and drives the MEM_WB register. mem_stall freezes upstream stages while
// an access is outstanding.
// Optional build macro: MEM_TIMEOUT_EN adds a WAIT-state watchdog that
// aborts an access after TIMEOUT cycles without an ack.
module mem_access_stage #(
    parameter int DMEM_AW = 12,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               Rst,
    input  logic               dbg,
    input  logic [31:0]        EX_MEM_alures,
    input  logic [31:0]        EX_MEM_dout_rs2,
    input  logic [4:0]         EX_MEM_rd,
    input  logic               EX_MEM_memread,
    input  logic               EX_MEM_memwrite,
    input  logic               EX_MEM_regwrite,
    input  logic [4:0]         EX_MEM_loadcntrl,
    input  logic [2:0]         EX_MEM_storecntrl,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic [3:0]         dmem_be,
    output logic [31:0]        dmem_wdata,
    input  logic [31:0]        dmem_rdata,
    input  logic               dmem_ack,
    output logic               mem_stall,
    output logic               mem_fault,
    output logic [4:0]         MEM_WB_rd,
    output logic               MEM_WB_regwrite,
    output logic [31:0]        WB_res
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t state_reg, state_next;

    // Memory interface registers
    logic               req_reg, req_next;
    logic               we_reg, we_next;
    logic [3:0]         be_reg, be_next;
    logic [DMEM_AW-1:0] addr_reg, addr_next;
    logic [31:0]        wdata_reg, wdata_next;
    logic               fault_reg, fault_next;

    // MEM_WB pipeline register
    logic [4:0]         wb_rd_reg, wb_rd_next;
    logic               wb_we_reg, wb_we_next;
    logic [31:0]        wb_res_reg, wb_res_next;

    // Context of the outstanding access (EX_MEM may not be trusted in WAIT)
    logic [3:0]         op_ld_reg, op_ld_next;      // {LHU, LBU, LH, LB}
    logic [1:0]         op_lo_reg, op_lo_next;
    logic [31:0]        op_res_reg, op_res_next;
    logic [4:0]         op_rd_reg, op_rd_next;
    logic               op_regwrite_reg, op_regwrite_next;
    logic               op_load_reg, op_load_next;

    // Decode of the incoming operation
    logic               is_load, is_store, mem_op;
    logic               word_acc, half_acc, misaligned;
    logic [1:0]         addr_lo;
    logic [3:0]         st_be;
    logic [31:0]        st_wdata;

    // Load lane extraction
    logic [7:0]         rd_byte [4];
    logic [15:0]        rd_half [2];
    logic [7:0]         sel_byte;
    logic [15:0]        sel_half;
    logic [31:0]        load_val;

    logic               timeout_hit;

    genvar gi;

    // Byte and halfword lanes of the returned read data
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte_lane
            assign rd_byte[gi] = dmem_rdata[8*gi +: 8];
        end
        for (gi = 0; gi < 2; gi++) begin : g_half_lane
            assign rd_half[gi] = dmem_rdata[16*gi +: 16];
        end
    endgenerate

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [CNT_W-1:0] cnt_reg;

    assign timeout_hit = (state_reg == WAIT) && !dmem_ack && (cnt_reg == CNT_W'(TIMEOUT));

    // Watchdog: holds 1 in IDLE so the first WAIT cycle counts as cycle 1
    always_ff @(posedge clk) begin
        if (!Rst) begin
            cnt_reg <= '0;
        end else if (state_reg == IDLE) begin
            cnt_reg <= CNT_W'(1);
        end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end
`else
    // TIMEOUT only matters when the watchdog is built in
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT);
    assign timeout_hit    = 1'b0;
`endif

    // Classify the op; a simultaneous read+write is treated as a load
    always_comb begin
        is_load    = EX_MEM_memread;
        is_store   = EX_MEM_memwrite && !EX_MEM_memread;
        mem_op     = is_load || is_store;
        addr_lo    = EX_MEM_alures[1:0];
        word_acc   = is_load ? EX_MEM_loadcntrl[2] : EX_MEM_storecntrl[2];
        half_acc   = is_load ? (EX_MEM_loadcntrl[1] || EX_MEM_loadcntrl[4])
                             : EX_MEM_storecntrl[1];
        misaligned = (word_acc && (addr_lo != 2'b00)) || (half_acc && addr_lo[0]);
    end

    // Replicate store data across lanes and pick the byte enables
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = EX_MEM_dout_rs2;
        if (EX_MEM_storecntrl[0]) begin
            st_be    = 4'b0001 << addr_lo;
            st_wdata = {4{EX_MEM_dout_rs2[7:0]}};
        end else if (EX_MEM_storecntrl[1]) begin
            st_be    = 4'b0011 << {addr_lo[1], 1'b0};
            st_wdata = {2{EX_MEM_dout_rs2[15:0]}};
        end
    end

    // Select the addressed lane and extend it per load type
    always_comb begin
        sel_byte = rd_byte[op_lo_reg];
        sel_half = rd_half[op_lo_reg[1]];
        load_val = dmem_rdata;
        if (op_ld_reg[0]) begin
            load_val = {{24{sel_byte[7]}}, sel_byte};
        end else if (op_ld_reg[2]) begin
            load_val = {24'd0, sel_byte};
        end else if (op_ld_reg[1]) begin
            load_val = {{16{sel_half[15]}}, sel_half};
        end else if (op_ld_reg[3]) begin
            load_val = {16'd0, sel_half};
        end
    end

    // FSM next-state, request formation, MEM_WB update and stall
    always_comb begin
        state_next       = state_reg;
        req_next         = req_reg;
        we_next          = we_reg;
        be_next          = be_reg;
        addr_next        = addr_reg;
        wdata_next       = wdata_reg;
        fault_next       = 1'b0;
        wb_rd_next       = wb_rd_reg;
        wb_we_next       = wb_we_reg;
        wb_res_next      = wb_res_reg;
        op_ld_next       = op_ld_reg;
        op_lo_next       = op_lo_reg;
        op_res_next      = op_res_reg;
        op_rd_next       = op_rd_reg;
        op_regwrite_next = op_regwrite_reg;
        op_load_next     = op_load_reg;
        mem_stall        = 1'b0;

        case (state_reg)
            IDLE: begin
                if (!dbg) begin
                    if (mem_op && !misaligned) begin
                        req_next         = 1'b1;
                        we_next          = is_store;
                        be_next          = is_store ? st_be : 4'b1111;
                        addr_next        = EX_MEM_alures[DMEM_AW+1:2];
                        wdata_next       = st_wdata;
                        op_ld_next       = {EX_MEM_loadcntrl[4], EX_MEM_loadcntrl[3],
                                            EX_MEM_loadcntrl[1], EX_MEM_loadcntrl[0]};
                        op_lo_next       = addr_lo;
                        op_res_next      = EX_MEM_alures;
                        op_rd_next       = EX_MEM_rd;
                        op_regwrite_next = EX_MEM_regwrite;
                        op_load_next     = is_load;
                        mem_stall        = 1'b1;
                        state_next       = WAIT;
                    end else if (mem_op) begin
                        // Misaligned: retire immediately without touching memory
                        fault_next  = 1'b1;
                        wb_rd_next  = EX_MEM_rd;
                        wb_we_next  = 1'b0;
                        wb_res_next = EX_MEM_alures;
                    end else begin
                        wb_rd_next  = EX_MEM_rd;
                        wb_we_next  = EX_MEM_regwrite && (EX_MEM_rd != 5'd0);
                        wb_res_next = EX_MEM_alures;
                    end
                end
            end
            WAIT: begin
                mem_stall = !dmem_ack && !timeout_hit;
                if (dmem_ack) begin
                    req_next    = 1'b0;
                    wb_rd_next  = op_rd_reg;
                    wb_we_next  = op_regwrite_reg && (op_rd_reg != 5'd0);
                    wb_res_next = op_load_reg ? load_val : op_res_reg;
                    state_next  = IDLE;
                end else if (timeout_hit) begin
                    req_next    = 1'b0;
                    fault_next  = 1'b1;
                    wb_rd_next  = op_rd_reg;
                    wb_we_next  = 1'b0;
                    wb_res_next = op_res_reg;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!Rst) begin
            state_reg       <= IDLE;
            req_reg         <= 1'b0;
            we_reg          <= 1'b0;
            be_reg          <= 4'b0000;
            addr_reg        <= '0;
            wdata_reg       <= 32'd0;
            fault_reg       <= 1'b0;
            wb_rd_reg       <= 5'd0;
            wb_we_reg       <= 1'b0;
            wb_res_reg      <= 32'd0;
            op_ld_reg       <= 4'b0000;
            op_lo_reg       <= 2'b00;
            op_res_reg      <= 32'd0;
            op_rd_reg       <= 5'd0;
            op_regwrite_reg <= 1'b0;
            op_load_reg     <= 1'b0;
        end else begin
            state_reg       <= state_next;
            req_reg         <= req_next;
            we_reg          <= we_next;
            be_reg          <= be_next;
            addr_reg        <= addr_next;
            wdata_reg       <= wdata_next;
            fault_reg       <= fault_next;
            wb_rd_reg       <= wb_rd_next;
            wb_we_reg       <= wb_we_next;
            wb_res_reg      <= wb_res_next;
            op_ld_reg       <= op_ld_next;
            op_lo_reg       <= op_lo_next;
            op_res_reg      <= op_res_next;
            op_rd_reg       <= op_rd_next;
            op_regwrite_reg <= op_regwrite_next;
            op_load_reg     <= op_load_next;
        end
    end

    assign dmem_req        = req_reg;
    assign dmem_we         = we_reg;
    assign dmem_be         = be_reg;
    assign dmem_addr       = addr_reg;
    assign dmem_wdata      = wdata_reg;
    assign mem_fault       = fault_reg;
    assign MEM_WB_rd       = wb_rd_reg;
    assign MEM_WB_regwrite = wb_we_reg;
    assign WB_res          = wb_res_reg;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage (default build).
module tb_mem_access_stage;

    localparam int DMEM_AW = 12;

    logic               clk = 1'b0;
    logic               Rst;
    logic               dbg;
    logic [31:0]        alures;
    logic [31:0]        rs2;
    logic [4:0]         rd;
    logic               memread;
    logic               memwrite;
    logic               regwrite;
    logic [4:0]         loadcntrl;
    logic [2:0]         storecntrl;
    logic               dmem_req;
    logic               dmem_we;
    logic [DMEM_AW-1:0] dmem_addr;
    logic [3:0]         dmem_be;
    logic [31:0]        dmem_wdata;
    logic [31:0]        dmem_rdata;
    logic               dmem_ack;
    logic               mem_stall;
    logic               mem_fault;
    logic [4:0]         MEM_WB_rd;
    logic               MEM_WB_regwrite;
    logic [31:0]        WB_res;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access_stage #(
        .DMEM_AW(DMEM_AW),
        .TIMEOUT(255)
    ) dut (
        .clk              (clk),
        .Rst              (Rst),
        .dbg              (dbg),
        .EX_MEM_alures    (alures),
        .EX_MEM_dout_rs2  (rs2),
        .EX_MEM_rd        (rd),
        .EX_MEM_memread   (memread),
        .EX_MEM_memwrite  (memwrite),
        .EX_MEM_regwrite  (regwrite),
        .EX_MEM_loadcntrl (loadcntrl),
        .EX_MEM_storecntrl(storecntrl),
        .dmem_req         (dmem_req),
        .dmem_we          (dmem_we),
        .dmem_addr        (dmem_addr),
        .dmem_be          (dmem_be),
        .dmem_wdata       (dmem_wdata),
        .dmem_rdata       (dmem_rdata),
        .dmem_ack         (dmem_ack),
        .mem_stall        (mem_stall),
        .mem_fault        (mem_fault),
        .MEM_WB_rd        (MEM_WB_rd),
        .MEM_WB_regwrite  (MEM_WB_regwrite),
        .WB_res           (WB_res)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %-16s got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %-16s 0x%08h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_op();
        memread    = 1'b0;
        memwrite   = 1'b0;
        loadcntrl  = 5'b00000;
        storecntrl = 3'b000;
        regwrite   = 1'b0;
        rd         = 5'd0;
        alures     = 32'd0;
        rs2        = 32'd0;
    endtask

    task automatic drive_load(input logic [31:0] addr, input logic [4:0] lc, input logic [4:0] dst);
        clear_op();
        alures    = addr;
        memread   = 1'b1;
        loadcntrl = lc;
        rd        = dst;
        regwrite  = 1'b1;
    endtask

    task automatic drive_store(input logic [31:0] addr, input logic [2:0] sc, input logic [31:0] data);
        clear_op();
        alures     = addr;
        memwrite   = 1'b1;
        storecntrl = sc;
        rs2        = data;
    endtask

    // Ack the outstanding access this cycle, then retire the op
    task automatic ack_with(input logic [31:0] data);
        dmem_rdata = data;
        dmem_ack   = 1'b1;
        #1 check("stall_on_ack", 32'(mem_stall), 32'd0);
        tick();
        dmem_ack = 1'b0;
        clear_op();
    endtask

    // One load with an immediate ack, checking the extended result
    task automatic load_case(input string tag, input logic [31:0] addr, input logic [4:0] lc,
                             input logic [31:0] data, input logic [31:0] exp);
        drive_load(addr, lc, 5'd6);
        tick();
        ack_with(data);
        check(tag, WB_res, exp);
    endtask

    initial begin
        Rst        = 1'b0;
        dbg        = 1'b0;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'd0;
        clear_op();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req", 32'(dmem_req), 32'd0);
        check("rst_be", 32'(dmem_be), 32'd0);
        check("rst_wb_res", WB_res, 32'd0);
        check("rst_wb_we", 32'(MEM_WB_regwrite), 32'd0);
        check("rst_fault", 32'(mem_fault), 32'd0);
        Rst = 1'b1;

        // ALU result pass-through, 1 cycle, no stall
        alures = 32'h1234_5678; rd = 5'd3; regwrite = 1'b1;
        #1 check("alu_stall", 32'(mem_stall), 32'd0);
        tick();
        check("alu_res", WB_res, 32'h1234_5678);
        check("alu_rd", 32'(MEM_WB_rd), 32'd3);
        check("alu_we", 32'(MEM_WB_regwrite), 32'd1);
        alures = 32'h0000_AAAA; rd = 5'd0; regwrite = 1'b1;
        tick();
        check("x0_we", 32'(MEM_WB_regwrite), 32'd0);
        check("x0_res", WB_res, 32'h0000_AAAA);

        // LW at 0x104, ack in the cycle after req
        drive_load(32'h104, 5'b00100, 5'd5);
        #1 check("lw_stall_issue", 32'(mem_stall), 32'd1);
        tick();
        check("lw_req", 32'(dmem_req), 32'd1);
        check("lw_addr", 32'(dmem_addr), 32'h041);
        check("lw_be", 32'(dmem_be), 32'hF);
        check("lw_we", 32'(dmem_we), 32'd0);
        check("lw_wb_hold", WB_res, 32'h0000_AAAA);
        ack_with(32'h8000_00F1);
        check("lw_res", WB_res, 32'h8000_00F1);
        check("lw_wb_we", 32'(MEM_WB_regwrite), 32'd1);
        check("lw_wb_rd", 32'(MEM_WB_rd), 32'd5);
        check("lw_req_drop", 32'(dmem_req), 32'd0);

        // Sub-word loads
        load_case("lb_res", 32'h103, 5'b00001, 32'h80FF_1234, 32'hFFFF_FF80);
        load_case("lbu_res", 32'h103, 5'b01000, 32'h80FF_1234, 32'h0000_0080);
        load_case("lh_res", 32'h102, 5'b00010, 32'h80FF_1234, 32'hFFFF_80FF);
        load_case("lhu_res", 32'h102, 5'b10000, 32'h80FF_1234, 32'h0000_80FF);

        // Stores
        drive_store(32'h202, 3'b010, 32'hDEAD_BEEF);
        #1 check("sh_stall", 32'(mem_stall), 32'd1);
        tick();
        check("sh_req", 32'(dmem_req), 32'd1);
        check("sh_we", 32'(dmem_we), 32'd1);
        check("sh_be", 32'(dmem_be), 32'hC);
        check("sh_wdata", dmem_wdata, 32'hBEEF_BEEF);
        check("sh_addr", 32'(dmem_addr), 32'h080);
        ack_with(32'd0);
        check("sh_wb_we", 32'(MEM_WB_regwrite), 32'd0);
        drive_store(32'h201, 3'b001, 32'hDEAD_BEEF);
        tick();
        check("sb_be", 32'(dmem_be), 32'h2);
        check("sb_wdata", dmem_wdata, 32'hEFEF_EFEF);
        ack_with(32'd0);
        drive_store(32'h300, 3'b100, 32'h0102_0304);
        tick();
        check("sw_be", 32'(dmem_be), 32'hF);
        check("sw_wdata", dmem_wdata, 32'h0102_0304);
        check("sw_addr", 32'(dmem_addr), 32'h0C0);
        ack_with(32'd0);

        // Misaligned LW and SH
        drive_load(32'h106, 5'b00100, 5'd7);
        #1 check("mis_stall", 32'(mem_stall), 32'd0);
        tick();
        check("mis_req", 32'(dmem_req), 32'd0);
        check("mis_fault", 32'(mem_fault), 32'd1);
        check("mis_rd", 32'(MEM_WB_rd), 32'd7);
        check("mis_we", 32'(MEM_WB_regwrite), 32'd0);
        clear_op();
        tick();
        check("mis_fault_end", 32'(mem_fault), 32'd0);
        drive_store(32'h203, 3'b010, 32'h1);
        tick();
        check("mis_sh_fault", 32'(mem_fault), 32'd1);
        check("mis_sh_req", 32'(dmem_req), 32'd0);
        clear_op();
        tick();

        // memread + memwrite behaves as a load
        drive_load(32'h104, 5'b00100, 5'd5);
        memwrite = 1'b1; storecntrl = 3'b001; rs2 = 32'h5555_5555;
        tick();
        check("both_we", 32'(dmem_we), 32'd0);
        check("both_be", 32'(dmem_be), 32'hF);
        ack_with(32'h1111_2222);
        check("both_res", WB_res, 32'h1111_2222);

        // dbg in IDLE blocks requests and MEM_WB updates
        dbg = 1'b1;
        drive_load(32'h104, 5'b00100, 5'd9);
        #1 check("dbg_stall", 32'(mem_stall), 32'd0);
        tick();
        check("dbg_req", 32'(dmem_req), 32'd0);
        check("dbg_wb_hold", WB_res, 32'h1111_2222);
        clear_op(); alures = 32'h55; rd = 5'd9; regwrite = 1'b1;
        tick();
        check("dbg_rd_hold", 32'(MEM_WB_rd), 32'd5);
        dbg = 1'b0;

        // dbg raised during WAIT: the access still completes
        drive_load(32'h104, 5'b00100, 5'd10);
        tick();
        dbg = 1'b1;
        ack_with(32'hCAFE_F00D);
        check("dbgw_res", WB_res, 32'hCAFE_F00D);
        check("dbgw_rd", 32'(MEM_WB_rd), 32'd10);
        dbg = 1'b0;

        // Reset during a long WAIT, then a late ack
        drive_load(32'h104, 5'b00100, 5'd5);
        #1 check("rw_stall_0", 32'(mem_stall), 32'd1);
        tick();
        for (int i = 1; i < 5; i++) begin
            check($sformatf("rw_stall_%0d", i), 32'(mem_stall), 32'd1);
            tick();
        end
        Rst = 1'b0;
        tick();
        Rst = 1'b1;
        clear_op();
        check("rw_req", 32'(dmem_req), 32'd0);
        check("rw_addr", 32'(dmem_addr), 32'd0);
        check("rw_be", 32'(dmem_be), 32'd0);
        check("rw_wb_res", WB_res, 32'd0);
        check("rw_wb_rd", 32'(MEM_WB_rd), 32'd0);
        alures = 32'h77; rd = 5'd4; regwrite = 1'b1;
        dmem_rdata = 32'hBAD0_BAD0;
        dmem_ack   = 1'b1;
        #1 check("late_stall", 32'(mem_stall), 32'd0);
        tick();
        dmem_ack = 1'b0;
        check("late_req", 32'(dmem_req), 32'd0);
        check("late_res", WB_res, 32'h77);
        check("late_we", 32'(MEM_WB_regwrite), 32'd1);
        clear_op();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Pipeline stage directly downstream of Execute. Consumes the EX_MEM register outputs and performs data-memory loads and stores over a req/ack handshake.
- Formats store data and byte enables, and extracts and extends load data.
- Drives the MEM_WB pipeline register used by write-back and by Execute forwarding (WB_res).
- Asserts mem_stall to freeze upstream stages while an access is outstanding.

Parameters:
- DMEM_AW, 12, word-address width of data memory (dmem_addr = EX_MEM_alures[DMEM_AW+1:2]).
- TIMEOUT, 255, maximum WAIT cycles before the access is aborted (used only with MEM_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, all logic on the rising edge
- Rst  in  1  synchronous, active-low reset
- dbg  in  1  debug freeze; blocks new accesses and MEM_WB updates
- EX_MEM_alures  in  32  ALU result; the byte address for memory operations
- EX_MEM_dout_rs2  in  32  store data
- EX_MEM_rd  in  5  destination register
- EX_MEM_memread  in  1  load
- EX_MEM_memwrite  in  1  store
- EX_MEM_regwrite  in  1  register write enable
- EX_MEM_loadcntrl  in  5  one-hot: [0]LB [1]LH [2]LW [3]LBU [4]LHU
- EX_MEM_storecntrl  in  3  one-hot: [0]SB [1]SH [2]SW
- dmem_req  out  1  access request, held high until ack
- dmem_we  out  1  1 = write
- dmem_addr  out  DMEM_AW  word address
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-aligned write data
- dmem_rdata  in  32  read data, valid with dmem_ack
- dmem_ack  in  1  single-cycle completion
- mem_stall  out  1  combinational; freezes IF/ID/EX and EX_MEM
- mem_fault  out  1  one-cycle pulse on misalignment or timeout
- MEM_WB_rd  out  5  registered destination register
- MEM_WB_regwrite  out  1  registered write enable
- WB_res  out  32  registered result

Behaviour:
- Reset (Rst == 0 at a clock edge):
  - State returns to IDLE.
  - dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, mem_fault, MEM_WB_rd, MEM_WB_regwrite and WB_res all go to 0.
  - Reset overrides an in-flight access; an ack arriving afterwards is ignored.
- FSM state IDLE:
  - A memory op (memread or memwrite) with dbg == 0 and an aligned address latches dmem_addr, dmem_we, dmem_be and dmem_wdata, sets dmem_req = 1, and moves to WAIT.
  - mem_stall = 1 combinationally in that same cycle.
- FSM state WAIT:
  - mem_stall = !dmem_ack; the request signals are held stable.
  - On dmem_ack: dmem_req drops at the next edge, MEM_WB is written at that edge, and the state returns to IDLE.
  - Minimum memory-op latency is 2 cycles (ack in the cycle after req).
- Non-memory op, IDLE, dbg == 0: MEM_WB captures alures, rd and regwrite at the next edge. Latency is 1 cycle and there is no stall.
- dbg == 1:
  - In IDLE, MEM_WB holds and no request is issued.
  - An access already in WAIT still completes and writes MEM_WB.
- Alignment rules:
  - LW/SW require addr[1:0] == 0.
  - LH/LHU/SH require addr[0] == 0.
  - On a violation: no request is issued, mem_fault pulses, and MEM_WB captures rd with regwrite = 0, in 1 cycle with no stall.
- Store formatting:
  - SB: be = 0001 << addr[1:0], wdata = {4{rs2[7:0]}}.
  - SH: be = 0011 << {addr[1],1'b0}, wdata = {2{rs2[15:0]}}.
  - SW: be = 1111, wdata = rs2.
- Load extraction:
  - The selected lane is rdata >> (8*addr[1:0]) for bytes, or >> (16*addr[1]) for halves.
  - LB/LH sign-extend to 32 bits; LBU/LHU zero-extend; LW takes the full word.
- Loads drive be = 1111 and we = 0.
- MEM_WB_regwrite is forced to 0 whenever rd == 0.
- A store writes MEM_WB with regwrite = EX_MEM_regwrite (normally 0).
- If memread and memwrite are both set, memwrite is ignored and the op is treated as a load.
- An ack seen in IDLE is ignored.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - An 8+ bit counter runs in WAIT.
  - When it reaches TIMEOUT without an ack, dmem_req drops, mem_fault pulses, MEM_WB captures rd with regwrite = 0, and the state returns to IDLE.
- Undefined: WAIT persists indefinitely; mem_fault is driven only by misalignment.

Test Plan:
- LW, alures = 0x104, memory word 0x8000_00F1, ack in the cycle after req → dmem_addr = 0x041, be = 1111, mem_stall high for 1 cycle, WB_res = 0x8000_00F1 with regwrite = 1 at cycle 2.
- LB, alures = 0x103, rdata = 0x80FF_1234 → WB_res = 0xFFFF_FF80. LBU at the same address → 0x0000_0080.
- SH, alures = 0x202, rs2 = 0xDEAD_BEEF → be = 1100, wdata = 0xBEEF_BEEF, we = 1. SB at 0x201 → be = 0010.
- LW, alures = 0x106 → no dmem_req, mem_fault pulses for 1 cycle, MEM_WB_regwrite = 0, no stall.
- Ack delayed 5 cycles, then Rst = 0 asserted during WAIT → mem_stall high for 5 cycles; after reset, req = 0 and all outputs = 0, and a late ack is ignored.
- With MEM_TIMEOUT_EN and TIMEOUT = 4, no ack → mem_fault at cycle 4 of WAIT, state returns to IDLE, regwrite = 0.
